sub_bytes_serial: RTL and testbench
===================================

Name: sub_bytes_serial

Overview:
- Forward AES SubBytes engine for the AES-128 encryption datapath.
- Accepts one 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per cycle through a bank of synchronous forward S-box ROMs.
- Presents the substituted state over a valid/ready output handshake.
- Trades area (ROM count) against latency. Sits between AddRoundKey and ShiftRows in the iterative round controller.

Parameters:
- BYTES_PER_CYCLE, 4, number of S-box ROMs and bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- N (localparam), 16/BYTES_PER_CYCLE, number of lookup steps per block.

Ports:
- CLK  input  1  rising-edge clock. The ROMs also run on CLK.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  INPUT holds a state to substitute.
- IN_READY  output  1  block can accept a state.
- INPUT  input  [0:127]  state; byte i = INPUT[8i:8i+7], byte 0 = row0/col0, column-major.
- OUT_VALID  output  1  OUTPUT holds a complete substituted state.
- OUT_READY  input  1  consumer takes OUTPUT.
- OUTPUT  output  [0:127]  substituted state, same byte ordering as INPUT.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST high at a CLK edge): state=IDLE, step counter=0, OUTPUT=128'h0, OUT_VALID=0, BUSY=0, IN_READY=1 in the following cycle. RST has priority over every other event. Reset mid-operation aborts the block with no output produced.
- ROM: BYTES_PER_CYCLE instances of the forward S-box ROM (ports CLK, Read_Enable, Read_Address[0:7], Read_Data[0:7]). Read_Data reflects the address registered at the previous edge when Read_Enable was high.
- FSM states: IDLE, BUSY_S, DRAIN, DONE.
- IDLE: IN_READY=1. When IN_VALID&&IN_READY at an edge (call this cycle 0): capture INPUT into the source register, counter=0, go to BUSY_S.
- BUSY_S, step k = 0..N-1, occupying cycle 1+k:
  - Read_Enable=1 on all ROMs.
  - ROM j address = source byte k*BYTES_PER_CYCLE+j.
  - At the end of cycle 1+k (for k≥1), capture ROM data from step k-1 into result bytes (k-1)*BYTES_PER_CYCLE+j.
  - Counter increments. After step N-1, go to DRAIN.
- DRAIN (cycle N+1):
  - Read_Enable=0.
  - Capture step N-1 data into the final result bytes.
  - Go to DONE.
- DONE (from cycle N+2):
  - OUT_VALID=1; OUTPUT is stable and equals the full result.
  - On OUT_VALID&&OUT_READY at an edge: OUT_VALID=0, go to IDLE.
  - OUT_READY low: hold indefinitely with no change to OUTPUT.
- Latency: OUT_VALID first high N+2 cycles after the acceptance cycle (6 for default, 3 for BYTES_PER_CYCLE=16). Minimum block period N+3 cycles (IDLE, N busy, DRAIN, DONE with OUT_READY=1).
- IN_READY=0 in BUSY_S, DRAIN and DONE. INPUT changes while busy are ignored; the source register is not reloaded. No overlap of blocks.
- OUTPUT register is partially overwritten during BUSY_S/DRAIN. It is meaningful only while OUT_VALID=1. After an output handshake it holds the last result until the next block's first capture.
- IN_VALID asserted in the same cycle as the DONE handshake is not accepted until the following IDLE cycle.
- BUSY = (state != IDLE).

Test Plan:
- Reset, then idle -> IN_READY=1, OUT_VALID=0, OUTPUT=0, BUSY=0.
- Default parameter, INPUT=193de3bea0f4e22b9ac68d2ae9f84808, IN_VALID for 1 cycle, OUT_READY=1 -> OUT_VALID high exactly 6 cycles after acceptance for 1 cycle; OUTPUT=d42711aee0bf98f1b8b45de51e415230.
- All-zero INPUT -> OUTPUT=636363...63 (16 bytes). All-FF INPUT -> 16161616...16. Each checked with BYTES_PER_CYCLE=1 (latency 18) and 16 (latency 3).
- OUT_READY held low 10 cycles in DONE -> OUT_VALID stays 1, OUTPUT stable, IN_READY stays 0 while IN_VALID=1 with a new state. After OUT_READY, the next block is accepted one cycle later.
- RST asserted during BUSY_S step 2 -> next cycle IDLE, OUT_VALID=0, OUTPUT=0. A following block with INPUT bytes 00..0f -> 637c777bf26b6fc53001672bfed7ab76.
- Back-to-back blocks with IN_VALID always high and OUT_READY always high -> one output per 7 cycles (default), each output correct per the FIPS-197 S-box.

Source files
------------

// File: rtl/sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// sub_bytes_serial
//   Forward AES SubBytes engine. One 128-bit state is accepted over a
//   valid/ready handshake and substituted BYTES_PER_CYCLE bytes per cycle
//   through a bank of synchronous forward S-box ROMs. The substituted state is
//   then offered over a valid/ready output handshake.
//
//   Ports
//     CLK        rising-edge clock (also clocks the ROMs)
//     RST        synchronous, active-high reset
//     IN_VALID   INPUT holds a state to substitute
//     IN_READY   block can accept a state (IDLE only)
//     INPUT      state, byte i = INPUT[8i:8i+7], column-major
//     OUT_VALID  OUTPUT holds a complete substituted state
//     OUT_READY  consumer takes OUTPUT
//     OUTPUT     substituted state, same byte ordering as INPUT
//     BUSY       high whenever the FSM is not in IDLE
//
//   Also contains sub_bytes_serial_sbox_rom, the synchronous forward S-box ROM.
// -----------------------------------------------------------------------------

module sub_bytes_serial_sbox_rom (
   input  logic       CLK,
   input  logic       Read_Enable,
   input  logic [0:7] Read_Address,
   output logic [0:7] Read_Data
);

   // FIPS-197 forward S-box, entry 0 in the most significant byte.
   localparam logic [0:2047] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [0:7] data_q;

   // Registered lookup; data holds while the read enable is low.
   always_ff @(posedge CLK) begin
      if (Read_Enable) begin
         data_q <= SBOX_TABLE[{Read_Address, 3'b000} +: 8];
      end
   end

   assign Read_Data = data_q;

endmodule

module sub_bytes_serial #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [0:127] INPUT,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [0:127] OUTPUT,
   output logic         BUSY
);

   localparam int N = 16 / BYTES_PER_CYCLE;

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
      $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_S = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [0:127] src_q, src_d;
   logic [0:127] res_q, res_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;

   logic         rom_en_s;
   logic         capture_s;
   logic [0:7]   rom_addr_s [BYTES_PER_CYCLE];
   logic [0:7]   rom_data_s [BYTES_PER_CYCLE];

   // Bit offset of byte (step*BYTES_PER_CYCLE + lane). Out-of-range steps wrap
   // harmlessly; they only occur when the ROMs are disabled.
   function automatic logic [6:0] bit_base(input logic [4:0] step, input int lane);
      int byte_idx;
      byte_idx = int'(step) * BYTES_PER_CYCLE + lane;
      return 7'(byte_idx * 8);
   endfunction

   // ROM bank: lane j looks up source byte k*BYTES_PER_CYCLE+j during step k.
   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_rom
      sub_bytes_serial_sbox_rom u_rom (
         .CLK          (CLK),
         .Read_Enable  (rom_en_s),
         .Read_Address (rom_addr_s[j]),
         .Read_Data    (rom_data_s[j])
      );
   end

   // ROM enable and address selection from the current step.
   always_comb begin
      rom_en_s = (state_q == BUSY_S);
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         rom_addr_s[j] = src_q[bit_base(cnt_q, j) +: 8];
      end
   end

   // Next-state, counter, capture and registered-flag logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      src_d       = src_q;
      res_d       = res_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (IN_VALID && in_ready_q) begin
               src_d   = INPUT;
               cnt_d   = 5'd0;
               state_d = BUSY_S;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY_S: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(N - 1)) begin
               state_d = DRAIN;
            end else begin
               state_d = BUSY_S;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            if (out_valid_q && OUT_READY) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // ROM data lags the address by one edge, so the bytes written now belong
      // to the previous step. In DRAIN the counter already reads N.
      capture_s = ((state_q == BUSY_S) && (cnt_q != 5'd0)) || (state_q == DRAIN);
      if (capture_s) begin
         for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            res_d[bit_base(cnt_q - 5'd1, j) +: 8] = rom_data_s[j];
         end
      end else begin
         res_d = res_q;
      end

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         src_q       <= 128'h0;
         res_q       <= 128'h0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         src_q       <= src_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUTPUT    = res_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_serial
//   Scoreboard bench for sub_bytes_serial. Expected states come from an
//   arithmetic S-box model (GF(2^8) inverse + affine map). The default
//   instance gets the main scenarios; two extra instances cover
//   BYTES_PER_CYCLE = 1 and 16.
// -----------------------------------------------------------------------------

module tb_sub_bytes_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1b;
         else       aa = {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] x);
      logic [7:0] b;
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gf_mul(b, x);   // x^254 = x^-1, 0 -> 0
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] sub_state_model(input logic [0:127] s);
      logic [0:127] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_model(s[8*i +: 8]);
      return r;
   endfunction

   // ---------------- default instance ----------------
   logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [0:127] in_data, out_data;

   sub_bytes_serial u_dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .INPUT     (in_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUTPUT    (out_data),
      .BUSY      (busy)
   );

   logic [0:127] exp_q[$];
   int           acc_q[$];
   logic [0:127] last_out = 128'h0;
   int           last_out_hs = 0;
   logic         prev_ov = 1'b0;
   logic         prev_hs = 1'b0;

   // Monitor: push on input handshake, compare on output handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (prev_hs) check_value("ov_one_cycle", out_valid, 1'b0);
         if (out_valid && !prev_ov && acc_q.size() != 0)
            check_value("latency", 128'(cyc - acc_q[0]), 128'(6));
         prev_hs = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_value("unexpected_out", out_valid, 1'b0);
            end else begin
               check_value("out_data", out_data, exp_q.pop_front());
               void'(acc_q.pop_front());
            end
            last_out    = out_data;
            last_out_hs = cyc;
            prev_hs     = 1'b1;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(sub_state_model(in_data));
            acc_q.push_back(cyc);
         end
         prev_ov = out_valid;
      end
   end

   task automatic wait_accept(output int acc);
      bit got;
      got = 1'b0;
      acc = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc;
            got = 1'b1;
         end
      end
      if (!got) check_value("accept_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic send_block(input logic [0:127] vec);
      int acc;
      in_valid = 1'b1;
      in_data  = vec;
      wait_accept(acc);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
      check_value("drain", 128'(exp_q.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   // ---------------- BYTES_PER_CYCLE = 1 and 16 instances ----------------
   for (genvar g = 0; g < 2; g++) begin : g_alt
      localparam int BPC = (g == 0) ? 1 : 16;
      localparam int LAT = 16 / BPC + 2;
      logic         a_rst, a_iv, a_ir, a_ov, a_or, a_busy;
      logic [0:127] a_in, a_out;
      bit           done_r = 1'b0;

      sub_bytes_serial #(.BYTES_PER_CYCLE(BPC)) u_dut (
         .CLK       (clk),
         .RST       (a_rst),
         .IN_VALID  (a_iv),
         .IN_READY  (a_ir),
         .INPUT     (a_in),
         .OUT_VALID (a_ov),
         .OUT_READY (a_or),
         .OUTPUT    (a_out),
         .BUSY      (a_busy)
      );

      initial begin
         int  acc;
         bit  got;
         logic [0:127] exp_v;
         a_rst = 1'b1; a_iv = 1'b0; a_in = 128'h0; a_or = 1'b1;
         repeat (2) @(posedge clk);
         #1 a_rst = 1'b0;
         for (int v = 0; v < 2; v++) begin
            a_in  = (v == 0) ? 128'h0 : {128{1'b1}};
            exp_v = (v == 0) ? {16{8'h63}} : {16{8'h16}};
            a_iv  = 1'b1;
            got = 1'b0; acc = 0;
            for (int t = 0; t < 20 && !got; t++) begin
               @(negedge clk);
               if (a_ir) begin acc = cyc; got = 1'b1; end
            end
            if (!got) check_value($sformatf("bpc%0d_accept", BPC), a_ir, 1'b1);
            @(posedge clk); #1 a_iv = 1'b0;
            got = 1'b0;
            for (int t = 0; t < LAT + 10 && !got; t++) begin
               @(negedge clk);
               if (a_ov) got = 1'b1;
            end
            check_value($sformatf("bpc%0d_latency", BPC), 128'(cyc - acc), 128'(LAT));
            check_value($sformatf("bpc%0d_out", BPC), a_out, exp_v);
            check_value($sformatf("bpc%0d_model", BPC), a_out, sub_state_model(a_in));
            @(posedge clk); #1;
         end
         done_r = 1'b1;
      end
   end

   // ---------------- main stimulus ----------------
   initial begin
      int  acc;
      int  accs[4];
      bit  got;
      rst = 1'b1; in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_value("rst_in_ready", in_ready, 1'b1);
      check_value("rst_out_valid", out_valid, 1'b0);
      check_value("rst_output", out_data, 128'h0);
      check_value("rst_busy", busy, 1'b0);
      @(posedge clk); #1;

      // FIPS-197 round-1 vector
      send_block(128'h193de3bea0f4e22b9ac68d2ae9f84808);
      @(negedge clk);
      check_value("busy_high", busy, 1'b1);
      check_value("in_ready_low", in_ready, 1'b0);
      wait_drain();
      check_value("fips_vec", last_out, 128'hd42711aee0bf98f1b8b45de51e415230);

      // Back-pressure in DONE
      out_ready = 1'b0;
      send_block(128'h0);
      got = 1'b0;
      for (int t = 0; t < 30 && !got; t++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      if (!got) check_value("bp_wait", out_valid, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = {128{1'b1}};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_value("bp_out_valid", out_valid, 1'b1);
         check_value("bp_output", out_data, {16{8'h63}});
         check_value("bp_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_accept(acc);
      in_valid = 1'b0;
      check_value("bp_next_accept", 128'(acc - last_out_hs), 128'(1));
      wait_drain();
      check_value("ff_vec", last_out, {16{8'h16}});

      // Reset during step 2
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      wait_accept(acc);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_value("abort_in_ready", in_ready, 1'b1);
      check_value("abort_out_valid", out_valid, 1'b0);
      check_value("abort_output", out_data, 128'h0);
      check_value("abort_busy", busy, 1'b0);
      @(posedge clk); #1;
      send_block(128'h000102030405060708090a0b0c0d0e0f);
      wait_drain();
      check_value("seq_vec", last_out, 128'h637c777bf26b6fc53001672bfed7ab76);

      // Back-to-back blocks
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         wait_accept(accs[i]);
      end
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++)
         check_value("b2b_period", 128'(accs[i] - accs[i-1]), 128'(7));
      wait_drain();

      for (int t = 0; t < 200 && !(g_alt[0].done_r && g_alt[1].done_r); t++) @(negedge clk);
      check_value("alt_done", {g_alt[0].done_r, g_alt[1].done_r}, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
